uart_tx_frame: RTL

Serial UART transmitter that pairs with the RXRX receiver. It uses the same line format: idle-high, 16x oversampled bit period, 7/8 data bits LSB first, optional odd/even parity, 1 or 2 stop bits. It accepts bytes over a valid/ready handshake and drives a single serial line into the receiver's input_signal. Framing controls (snum, dnum, par) use the receiver's encoding so one control bank drives both ends.

---
 rtl/uart_tx_frame.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: oversampled serial UART transmitter.
// Line format: idle-high, start bit 0, 7 or 8 data bits LSB first,
// optional odd/even parity, 1 or 2 stop bits. Each bit lasts OVERSAMPLE
// clocks. Bytes are accepted over a valid/ready handshake.
// Framing controls share the encoding of the matching receiver.
// Optional build macro TX_B2B_EN lets the next byte be accepted in the final
// clock of the last stop bit, so frames follow each other with no idle gap.
// With TX_B2B_EN undefined, at least one idle clock separates frames.
module uart_tx_frame #(
  parameter int OVERSAMPLE = 16,
  parameter int CNT_W      = 8
) (
  input  logic       TX_clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       snum,
  input  logic       dnum,
  input  logic [1:0] par,
  output logic       output_signal,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam logic [CNT_W-1:0] OS_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] OS_PRE  = CNT_W'(OVERSAMPLE - 2);

  logic [2:0]       state;
  logic [CNT_W-1:0] os_cnt;
  logic [2:0]       bit_cnt;   // data bit index in DATA, stop bit index in STOP
  logic [7:0]       shreg;     // remaining data bits, next one in bit 1
  logic             par_bit;   // parity bit precomputed at acceptance
  logic             par_en;
  logic             two_stop;
  logic             seven;

  logic accept;
  logic last_tick;
  logic data_last;
  logic stop_last;
  logic data_x;

  // Ready: idle (and, in back-to-back builds, the very last frame clock)
`ifdef TX_B2B_EN
  assign tx_ready = ((state == IDLE) || frame_done) && !rst;
`else
  assign tx_ready = (state == IDLE) && !rst;
`endif

  assign accept    = tx_valid && tx_ready;
  assign last_tick = (os_cnt == OS_LAST);
  assign data_last = (bit_cnt == (seven ? 3'd6 : 3'd7));
  assign stop_last = (bit_cnt == (two_stop ? 3'd1 : 3'd0));
  // Bit 7 is left out of the parity in 7-bit mode since it is never sent.
  assign data_x    = dnum ? ^tx_data[6:0] : ^tx_data;

  // Frame sequencer: latches the byte and framing, then walks the bit periods
  // NOTE: every register here uses non-blocking assignment so all updates see
  // the pre-edge values; a blocking '=' would leak new values into later lines.
  always_ff @(posedge TX_clk) begin
    if (rst) begin
      state         <= IDLE;
      os_cnt        <= '0;
      bit_cnt       <= '0;
      shreg         <= '0;
      par_bit       <= 1'b0;
      par_en        <= 1'b0;
      two_stop      <= 1'b0;
      seven         <= 1'b0;
      output_signal <= 1'b1;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (accept) begin
        state         <= START;
        os_cnt        <= '0;
        bit_cnt       <= '0;
        shreg         <= tx_data;
        par_bit       <= (par == 2'b01) ? ~data_x : data_x;
        par_en        <= (par == 2'b01) || (par == 2'b10);
        two_stop      <= snum;
        seven         <= dnum;
        output_signal <= 1'b0;
        busy          <= 1'b1;
      end else if (state != IDLE) begin
        os_cnt <= last_tick ? '0 : os_cnt + 1'b1;
        // Pulse lands on the final clock of the last stop bit.
        if ((state == STOP) && stop_last && (os_cnt == OS_PRE))
          frame_done <= 1'b1;
        if (last_tick) begin
          case (state)
            START: begin
              state         <= DATA;
              output_signal <= shreg[0];
            end
            DATA: begin
              if (data_last) begin
                bit_cnt <= '0;
                if (par_en) begin
                  state         <= PARITY;
                  output_signal <= par_bit;
                end else begin
                  state         <= STOP;
                  output_signal <= 1'b1;
                end
              end else begin
                bit_cnt       <= bit_cnt + 3'd1;
                shreg         <= {1'b1, shreg[7:1]};
                output_signal <= shreg[1];
              end
            end
            PARITY: begin
              state         <= STOP;
              output_signal <= 1'b1;
            end
            STOP: begin
              output_signal <= 1'b1;
              if (stop_last) begin
                state   <= IDLE;
                bit_cnt <= '0;
                busy    <= 1'b0;
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
            default: begin
              state         <= IDLE;
              output_signal <= 1'b1;
              busy          <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule
